// File: rtl/ysyx_25040105_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_25040105_ifu -- instruction fetch unit
//
// Fetches one instruction word at a time from instruction memory and holds it
// for decode. At most one fetch is outstanding. A redirect from execute
// replaces the PC in any state. A response to a fetch that a redirect has made
// stale is discarded.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous, active-high reset
//   req_valid_o      fetch request to instruction memory
//   req_ready_i      memory accepts the request this cycle
//   req_addr_o       fetch address (current pc)
//   rsp_valid_i      fetch data valid
//   rsp_data_i       fetched instruction word
//   out_valid_o      instruction available to decode
//   out_ready_i      decode consumes the instruction
//   out_inst_o       held instruction
//   out_pc_o         PC of out_inst_o
//   redirect_valid_i control-flow redirect from execute
//   redirect_pc_i    redirect target
//   misalign_err_o   sticky misaligned-redirect flag
//
// Build option
//   YSYX_25040105_IFU_MISALIGN_EN  defined: a redirect whose target is not
//   word aligned sets misalign_err_o, leaves pc unchanged and halts fetching
//   in IDLE until reset. Undefined: the target's low two bits are cleared and
//   misalign_err_o is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request; steps to REQ next cycle (stays while halted)
// REQ   | req_valid_o high at pc; handshake moves to WAIT
// WAIT  | one fetch outstanding; response latched, or dropped when stale
// HOLD  | out_valid_o high; out_inst_o/out_pc_o stable until consumed
// ----------------------------------------------------------------------------
module ysyx_25040105_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        misalign_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;

    logic        halt_q;
    logic        take_redir;
    logic        bad_redir;
    logic [31:0] redir_tgt;

`ifdef YSYX_25040105_IFU_MISALIGN_EN
    assign redir_tgt = redirect_pc_i;
    assign bad_redir = |redirect_pc_i[1:0];

    // Sticky halt: once set only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halt_q <= 1'b0;
        end else if (take_redir && bad_redir) begin
            halt_q <= 1'b1;
        end
    end
`else
    logic unused_redir_lsb;

    assign redir_tgt        = {redirect_pc_i[31:2], 2'b00};
    assign bad_redir        = 1'b0;
    assign halt_q           = 1'b0;
    assign unused_redir_lsb = ^redirect_pc_i[1:0];
`endif

    // A halted unit accepts no further redirects.
    assign take_redir = redirect_valid_i && !halt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        opc_d   = opc_q;

        case (state_q)
            S_IDLE: begin
                if (!halt_q) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (req_ready_i) begin
                    state_d = S_WAIT;
                    // The request just issued was for the old pc.
                    if (take_redir) begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (rsp_valid_i) begin
                    if (take_redir || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = rsp_data_i;
                        opc_d   = pc_q;
                        state_d = S_HOLD;
                    end
                end else if (take_redir) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (take_redir) begin
                    state_d = S_REQ;
                end else if (out_ready_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides whatever the state decided about pc.
        if (take_redir) begin
            if (bad_redir) begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
                pc_d    = pc_q;
            end else begin
                pc_d = redir_tgt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= 32'h0;
            opc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
        end
    end

    assign req_valid_o    = (state_q == S_REQ);
    assign req_addr_o     = pc_q;
    assign out_valid_o    = (state_q == S_HOLD);
    assign out_inst_o     = inst_q;
    assign out_pc_o       = opc_q;
    assign misalign_err_o = halt_q;

endmodule

// File: doc/ysyx_25040105_ifu.md
YSYX_25040105_IFU -- requirements
Module: ysyx_25040105_ifu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 32'h8000_0000: PC value loaded at reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  output  1  instruction-memory fetch request.
REQ-006 req_ready  input  1  memory accepts the request this cycle.
REQ-007 req_addr  output  32  fetch address; equals pc.
REQ-008 rsp_valid  input  1  fetch data valid.
REQ-009 rsp_data  input  32  fetched instruction word.
REQ-010 out_valid  output  1  instruction available to decode.
REQ-011 out_ready  input  1  decode consumes the instruction.
REQ-012 out_inst  output  32  held instruction.
REQ-013 out_pc  output  32  PC of out_inst.
REQ-014 redirect_valid  input  1  control-flow redirect from execute.
REQ-015 redirect_pc  input  32  redirect target.
REQ-016 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT and HOLD; at most one fetch SHALL be outstanding.
REQ-018 IDLE: the FSM SHALL go to REQ on the next cycle; req_valid=0 and out_valid=0.
REQ-019 REQ: req_valid=1 and req_addr=pc; the handshake req_valid&req_ready SHALL move the FSM to WAIT.
REQ-020 WAIT: on rsp_valid the block SHALL register out_inst=rsp_data and out_pc=pc, then go to HOLD; latency from handshake to out_valid SHALL be 1 cycle after rsp_valid.
REQ-021 HOLD: out_valid=1 and out_inst/out_pc SHALL be stable; on out_ready, pc SHALL become pc+4 (32-bit wrap) and the FSM SHALL go to REQ.
REQ-022 rsp_valid outside WAIT SHALL be ignored.
REQ-023 A redirect in any state SHALL load pc<=redirect_pc; redirect SHALL take priority over out_ready and over the pc+4 increment.
REQ-024 Redirect in HOLD: out_valid SHALL drop next cycle, no handoff SHALL occur, and the FSM SHALL go to REQ.
REQ-025 Redirect in REQ without req_ready: the FSM SHALL stay in REQ and issue the new pc next cycle.
REQ-026 Redirect in REQ with req_ready: the FSM SHALL go to WAIT with the drop flag set.
REQ-027 Redirect in WAIT without rsp_valid: the drop flag SHALL be set and the FSM SHALL stay in WAIT.
REQ-028 WAIT with the drop flag set and rsp_valid: the response SHALL be discarded, the drop flag cleared, and the FSM SHALL go to REQ.
REQ-029 Redirect in WAIT coincident with rsp_valid: the response SHALL be discarded and the FSM SHALL go to REQ.
REQ-030 pc+4 wrap 32'hFFFF_FFFC->32'h0000_0000 SHALL occur without error.

Reset
REQ-031 On rst, the block SHALL set: pc=RESET_PC, FSM=IDLE, drop flag=0, req_valid=0, out_valid=0, out_inst=0, out_pc=0, misalign_err=0.
REQ-032 rst mid-operation SHALL abandon any outstanding fetch; a response arriving after rst SHALL be ignored by REQ-022.

Configuration
REQ-033 When macro YSYX_25040105_IFU_MISALIGN_EN is defined, a redirect with redirect_pc[1:0]!=0 SHALL set misalign_err=1 (sticky until rst), leave pc unchanged, and force FSM=IDLE-halt with no further requests until rst.
REQ-034 Without YSYX_25040105_IFU_MISALIGN_EN, redirect_pc[1:0] SHALL be forced to 2'b00 and misalign_err SHALL be tied to 0.

Verification
REQ-035 Reset, then req_ready=1 and a 1-cycle rsp with 32'h00100093 -> req_addr=0x80000000; out_valid=1 with out_inst=0x00100093 and out_pc=0x80000000.
REQ-036 Hold out_ready=0 for 5 cycles, then pulse it -> out_inst stable throughout; next req_addr=0x80000004.
REQ-037 Redirect to 0x80000100 while in WAIT, stale rsp 0xDEADBEEF -> stale response dropped; next req_addr=0x80000100; out_inst is never 0xDEADBEEF.
REQ-038 Redirect coincident with out_ready in HOLD at pc 0x80000008 -> next req_addr=redirect_pc, not 0x8000000C.
REQ-039 pc=0xFFFFFFFC consumed -> next req_addr=0x00000000.
REQ-040 With the macro defined, redirect to 0x80000102 -> misalign_err=1 and req_valid stays 0 until rst; without the macro -> req_addr=0x80000100.
